// File: rtl/alu_operand_stage.sv
// ID/EX operand stage for the 16-bit ALU: registers decoded operands, forwards
// results from EX/MEM and MEM/WB, and raises a load-use stall with an EX bubble.
module alu_operand_stage #(
  parameter int WIDTH = 16,
  parameter int RAW   = 3,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RAW-1:0]   id_rs,
  input  logic [RAW-1:0]   id_rt,
  input  logic [RAW-1:0]   id_rd,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_use_imm,
  input  logic [OPW-1:0]   id_alu_op,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  input  logic             ex_hold,
  input  logic [RAW-1:0]   ex_mem_rd,
  input  logic             ex_mem_reg_write,
  input  logic [WIDTH-1:0] ex_mem_result,
  input  logic [RAW-1:0]   mem_wb_rd,
  input  logic             mem_wb_reg_write,
  input  logic [WIDTH-1:0] mem_wb_result,
  output logic             stall,
  output logic [WIDTH-1:0] alu_i1,
  output logic [WIDTH-1:0] alu_i2,
  output logic [OPW-1:0]   alu_op,
  output logic             ex_valid,
  output logic [RAW-1:0]   ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic [WIDTH-1:0] ex_store_data
);

  logic             ex_valid_reg;
  logic [RAW-1:0]   ex_rd_reg;
  logic [WIDTH-1:0] imm_reg;
  logic             use_imm_reg;
  logic [OPW-1:0]   alu_op_reg;
  logic             reg_write_reg;
  logic             mem_read_reg;

  logic lu;
  logic bubble;
  logic capture;

  logic [RAW-1:0]   id_src   [2];
  logic [WIDTH-1:0] id_data  [2];
  logic [WIDTH-1:0] fwd_data [2];

  assign id_src[0]  = id_rs;
  assign id_src[1]  = id_rt;
  assign id_data[0] = id_rs_data;
  assign id_data[1] = id_rt_data;

  assign lu = id_valid & ex_valid_reg & mem_read_reg & (ex_rd_reg != '0) &
              ((ex_rd_reg == id_rs) | (ex_rd_reg == id_rt));

  // Reset forces stall low immediately, even while downstream is holding.
  assign stall = rst_n & (lu | ex_hold);

  always_comb begin
    bubble  = 1'b0;
    capture = 1'b0;
    if (flush)        bubble  = 1'b1;
    else if (ex_hold) ;
    else if (lu)      bubble  = 1'b1;
    else              capture = 1'b1;
  end

  // Per-operand: capture-time writeback bypass, source register, and EX forwarding mux.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
      logic [RAW-1:0]   src_reg;
      logic [WIDTH-1:0] data_reg;
      logic [WIDTH-1:0] cap_data;

      assign cap_data = (mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == id_src[gi]))
                        ? mem_wb_result : id_data[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          src_reg  <= '0;
          data_reg <= '0;
        end else if (bubble) begin
          src_reg  <= '0;
          data_reg <= '0;
        end else if (capture) begin
          src_reg  <= id_src[gi];
          data_reg <= cap_data;
        end
      end

      assign fwd_data[gi] =
        (ex_mem_reg_write && (ex_mem_rd == src_reg) && (src_reg != '0)) ? ex_mem_result :
        (mem_wb_reg_write && (mem_wb_rd == src_reg) && (src_reg != '0)) ? mem_wb_result :
        data_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg  <= 1'b0;
      ex_rd_reg     <= '0;
      imm_reg       <= '0;
      use_imm_reg   <= 1'b0;
      alu_op_reg    <= '0;
      reg_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
    end else if (bubble) begin
      ex_valid_reg  <= 1'b0;
      ex_rd_reg     <= '0;
      imm_reg       <= '0;
      use_imm_reg   <= 1'b0;
      alu_op_reg    <= '0;
      reg_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
    end else if (capture) begin
      ex_valid_reg  <= id_valid;
      ex_rd_reg     <= id_rd;
      imm_reg       <= id_imm;
      use_imm_reg   <= id_use_imm;
      alu_op_reg    <= id_alu_op;
      reg_write_reg <= id_reg_write & id_valid;
      mem_read_reg  <= id_mem_read & id_valid;
    end
  end

  // An empty EX slot presents ADD 0,0 so the ALU never sees stale data.
  assign alu_i1        = ex_valid_reg ? fwd_data[0] : '0;
  assign alu_i2        = ex_valid_reg ? (use_imm_reg ? imm_reg : fwd_data[1]) : '0;
  assign alu_op        = ex_valid_reg ? alu_op_reg : '0;
  assign ex_store_data = ex_valid_reg ? fwd_data[1] : '0;
  assign ex_valid      = ex_valid_reg;
  assign ex_rd         = ex_rd_reg;
  assign ex_reg_write  = reg_write_reg;
  assign ex_mem_read   = mem_read_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus random traffic checked
// every cycle against an instruction-level model of the EX slot.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic        id_use_imm;
  logic [2:0]  id_alu_op;
  logic        id_reg_write, id_mem_read;
  logic        flush, ex_hold;
  logic [2:0]  ex_mem_rd;
  logic        ex_mem_reg_write;
  logic [15:0] ex_mem_result;
  logic [2:0]  mem_wb_rd;
  logic        mem_wb_reg_write;
  logic [15:0] mem_wb_result;
  logic        stall;
  logic [15:0] alu_i1, alu_i2;
  logic [2:0]  alu_op;
  logic        ex_valid;
  logic [2:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read;
  logic [15:0] ex_store_data;

  int n_cmp = 0;
  int n_bad = 0;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_op(id_alu_op), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .ex_hold(ex_hold), .ex_mem_rd(ex_mem_rd),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_result(ex_mem_result),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .mem_wb_result(mem_wb_result), .stall(stall), .alu_i1(alu_i1), .alu_i2(alu_i2),
    .alu_op(alu_op), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  // The instruction currently sitting in EX, as the model sees it.
  typedef struct packed {
    logic        v;
    logic [2:0]  rs, rt, rd;
    logic [15:0] a, b, imm;
    logic        ui;
    logic [2:0]  op;
    logic        rw, mr;
  } ex_t;

  ex_t m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] reg_value(input logic [2:0] r, input logic [15:0] held);
    if (r == 3'd0) return held;
    if (ex_mem_reg_write && ex_mem_rd == r) return ex_mem_result;
    if (mem_wb_reg_write && mem_wb_rd == r) return mem_wb_result;
    return held;
  endfunction

  function automatic logic [15:0] read_at_id(input logic [2:0] r, input logic [15:0] rf);
    if (mem_wb_reg_write && r != 3'd0 && mem_wb_rd == r) return mem_wb_result;
    return rf;
  endfunction

  function automatic logic load_use();
    return id_valid && m.v && m.mr && m.rd != 3'd0 && (m.rd == id_rs || m.rd == id_rt);
  endfunction

  task automatic check_model();
    logic [15:0] e1, e2, es;
    e1 = m.v ? reg_value(m.rs, m.a) : 16'h0;
    es = m.v ? reg_value(m.rt, m.b) : 16'h0;
    e2 = m.v ? (m.ui ? m.imm : es) : 16'h0;
    chk("stall", {31'd0, stall}, {31'd0, rst_n && (load_use() || ex_hold)});
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.v});
    chk("alu_i1", {16'd0, alu_i1}, {16'd0, e1});
    chk("alu_i2", {16'd0, alu_i2}, {16'd0, e2});
    chk("alu_op", {29'd0, alu_op}, {29'd0, m.v ? m.op : 3'd0});
    chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m.rw});
    chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m.mr});
    chk("ex_store_data", {16'd0, ex_store_data}, {16'd0, es});
    if (m.v) chk("ex_rd", {29'd0, ex_rd}, {29'd0, m.rd});
  endtask

  task automatic model_step();
    if (!rst_n || flush) m = '0;
    else if (ex_hold) ;
    else if (load_use()) m = '0;
    else begin
      m.v   = id_valid;
      m.rs  = id_rs;
      m.rt  = id_rt;
      m.rd  = id_rd;
      m.a   = read_at_id(id_rs, id_rs_data);
      m.b   = read_at_id(id_rt, id_rt_data);
      m.imm = id_imm;
      m.ui  = id_use_imm;
      m.op  = id_alu_op;
      m.rw  = id_reg_write && id_valid;
      m.mr  = id_mem_read && id_valid;
    end
  endtask

  // Inputs are set at the falling edge; tick checks, crosses the rising edge, returns at the next falling edge.
  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_use_imm = 0; id_alu_op = 0; id_reg_write = 0; id_mem_read = 0;
    flush = 0; ex_hold = 0; ex_mem_rd = 0; ex_mem_reg_write = 0; ex_mem_result = 0;
    mem_wb_rd = 0; mem_wb_reg_write = 0; mem_wb_result = 0;
  endtask

  task automatic issue(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                       input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic mr);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = a; id_rt_data = b;
    id_alu_op = op; id_reg_write = 1; id_mem_read = mr; id_use_imm = 0; id_imm = 0;
  endtask

  initial begin
    m = '0;
    rst_n = 0;
    idle();
    @(negedge clk);
    tick();
    rst_n = 1;
    tick();

    // simple capture, one-cycle latency
    issue(3'd1, 3'd2, 3'd5, 16'h0005, 16'h0003, 3'b001, 0);
    tick();
    idle();
    #1;
    chk("t2_i1", {16'd0, alu_i1}, 32'h0005);
    chk("t2_i2", {16'd0, alu_i2}, 32'h0003);
    chk("t2_op", {29'd0, alu_op}, 32'd1);
    tick();

    // forwarding priority, then r0 never forwarded
    issue(3'd2, 3'd1, 3'd6, 16'h0007, 16'h0001, 3'b010, 0);
    tick();
    idle();
    ex_hold = 1;
    ex_mem_rd = 3'd2; ex_mem_reg_write = 1; ex_mem_result = 16'h1234;
    mem_wb_rd = 3'd2; mem_wb_reg_write = 1; mem_wb_result = 16'hBEEF;
    #1;
    chk("t3_exmem", {16'd0, alu_i1}, 32'h1234);
    ex_mem_reg_write = 0;
    #1;
    chk("t3_memwb", {16'd0, alu_i1}, 32'hBEEF);
    tick();
    idle();
    issue(3'd0, 3'd1, 3'd6, 16'h0009, 16'h0001, 3'b010, 0);
    tick();
    idle();
    ex_hold = 1;
    ex_mem_rd = 3'd0; ex_mem_reg_write = 1; ex_mem_result = 16'h1234;
    mem_wb_rd = 3'd0; mem_wb_reg_write = 1; mem_wb_result = 16'hBEEF;
    #1;
    chk("t3_r0", {16'd0, alu_i1}, 32'h0009);
    tick();
    idle();

    // load-use: stall, bubble, then capture with load data from MEM/WB
    issue(3'd1, 3'd1, 3'd3, 16'h0100, 16'h0000, 3'b000, 1);
    tick();
    issue(3'd3, 3'd0, 3'd4, 16'h0BAD, 16'h0000, 3'b010, 0);
    #1;
    chk("t4_stall", {31'd0, stall}, 32'd1);
    tick();
    ex_mem_rd = 3'd3; ex_mem_reg_write = 1; ex_mem_result = 16'h0100;
    #1;
    chk("t4_bubble", {31'd0, ex_valid}, 32'd0);
    chk("t4_nostall", {31'd0, stall}, 32'd0);
    tick();
    idle();
    mem_wb_rd = 3'd3; mem_wb_reg_write = 1; mem_wb_result = 16'h5A5A;
    #1;
    chk("t4_valid", {31'd0, ex_valid}, 32'd1);
    chk("t4_load_fwd", {16'd0, alu_i1}, 32'h5A5A);
    tick();
    idle();

    // flush outranks ex_hold and load-use
    issue(3'd1, 3'd1, 3'd3, 16'h0100, 16'h0000, 3'b000, 1);
    tick();
    issue(3'd3, 3'd0, 3'd4, 16'h0BAD, 16'h0000, 3'b010, 0);
    ex_hold = 1; flush = 1;
    #1;
    chk("t5_stall", {31'd0, stall}, 32'd1);
    tick();
    idle();
    #1;
    chk("t5_valid", {31'd0, ex_valid}, 32'd0);
    chk("t5_rw", {31'd0, ex_reg_write}, 32'd0);
    tick();

    // same-cycle writeback bypass at capture, immediate operand
    issue(3'd4, 3'd5, 3'd6, 16'h0011, 16'h0033, 3'b011, 0);
    id_use_imm = 1; id_imm = 16'hFFFC;
    mem_wb_rd = 3'd4; mem_wb_reg_write = 1; mem_wb_result = 16'h00AA;
    tick();
    idle();
    #1;
    chk("t6_i1", {16'd0, alu_i1}, 32'h00AA);
    chk("t6_i2", {16'd0, alu_i2}, 32'hFFFC);
    chk("t6_store", {16'd0, ex_store_data}, 32'h0033);
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 7) != 0);
      id_rs = 3'($urandom_range(0, 7)); id_rt = 3'($urandom_range(0, 7));
      id_rd = 3'($urandom_range(0, 7));
      id_rs_data = 16'($urandom); id_rt_data = 16'($urandom); id_imm = 16'($urandom);
      id_use_imm = 1'($urandom_range(0, 1)); id_alu_op = 3'($urandom_range(0, 7));
      id_reg_write = 1'($urandom_range(0, 1)); id_mem_read = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 15) == 0); ex_hold = ($urandom_range(0, 7) == 0);
      ex_mem_rd = 3'($urandom_range(0, 7)); ex_mem_reg_write = 1'($urandom_range(0, 1));
      ex_mem_result = 16'($urandom);
      mem_wb_rd = 3'($urandom_range(0, 7)); mem_wb_reg_write = 1'($urandom_range(0, 1));
      mem_wb_result = 16'($urandom);
      tick();
    end
    idle();

    // asynchronous reset in the middle of a load-use stall
    issue(3'd1, 3'd1, 3'd3, 16'h0100, 16'h0000, 3'b000, 1);
    tick();
    issue(3'd3, 3'd3, 3'd4, 16'h0BAD, 16'h0000, 3'b101, 0);
    #1;
    chk("t1_pre_stall", {31'd0, stall}, 32'd1);
    rst_n = 0;
    m = '0;
    #1;
    chk("t1_valid", {31'd0, ex_valid}, 32'd0);
    chk("t1_i1", {16'd0, alu_i1}, 32'h0);
    chk("t1_i2", {16'd0, alu_i2}, 32'h0);
    chk("t1_op", {29'd0, alu_op}, 32'd0);
    chk("t1_stall", {31'd0, stall}, 32'd0);
    tick();
    rst_n = 1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
